// File: rtl/jtframe_rommux_pkg.sv
// Shared types and helpers for the MiST ROM read multiplexer.
// FSM state encoding and round-robin pointer arithmetic.
package jtframe_rommux_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } rommux_st_t;

    localparam int CH_DEF  = 4;
    localparam int CHW_DEF = $clog2(CH_DEF);

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/jtframe_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr.
// The pointer register lives in the parent.
module jtframe_rr_arbiter #(
    parameter int CH  = 4,
    parameter int CHW = $clog2(CH)
)(
    input  logic [CH-1:0]  req,
    input  logic [CHW-1:0] ptr,
    output logic [CH-1:0]  gnt,
    output logic [CHW-1:0] idx,
    output logic           any
);

    logic [CHW-1:0] j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = '0;
        // walk backwards so the requester closest to ptr overwrites last
        for (int k = CH-1; k >= 0; k--) begin
            j = CHW'((int'(ptr) + k) % CH);
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = j;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtframe_mist_rommux.sv
// N-channel round-robin ROM read arbiter in front of the SDRAM controller.
// Optional per-channel one-entry read cache: JTFRAME_ROMMUX_CACHE_EN.
module jtframe_mist_rommux #(
    parameter int CH = 4,
    parameter int AW = 22,
    parameter int DW = 32
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            downloading,
    input  logic            loop_rst,
    input  logic [CH-1:0]   ch_req,
    input  logic [CH*AW-1:0] ch_addr,
    output logic [CH-1:0]   ch_ok,
    output logic [DW-1:0]   ch_dout,
    output logic            sdram_req,
    output logic [AW-1:0]   sdram_addr,
    input  logic            sdram_ack,
    input  logic            sdram_rdy,
    input  logic [DW-1:0]   data_read
);
    import jtframe_rommux_pkg::*;

    localparam int CHW = $clog2(CH);

    rommux_st_t     st, st_nx;
    logic [CHW-1:0] ptr, win, gnt_idx;
    logic [CH-1:0]  gnt;
    logic           gnt_any, blocked, fetch_ok, hit_any;
    logic [AW-1:0]  gnt_addr, win_addr;

    assign blocked   = downloading | loop_rst;
    assign sdram_req = (st == ISSUE);

    jtframe_rr_arbiter #(.CH(CH)) u_arb (
        .req (ch_req),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    always_comb begin
        gnt_addr = '0;
        win_addr = '0;
        for (int i = 0; i < CH; i++) begin
            if (gnt[i])
                gnt_addr = ch_addr[i*AW +: AW];
            if (CHW'(i) == win)
                win_addr = ch_addr[i*AW +: AW];
        end
    end

    // data is only delivered if the client still wants this exact word
    assign fetch_ok = ch_req[win] && (win_addr == sdram_addr) && !downloading;

`ifdef JTFRAME_ROMMUX_CACHE_EN
    logic [CH-1:0]  c_valid, c_hit, hit_gnt;
    logic [AW-1:0]  c_tag  [CH];
    logic [DW-1:0]  c_data [CH];
    logic [CHW-1:0] hit_idx;

    always_comb begin
        c_hit = '0;
        for (int i = 0; i < CH; i++)
            c_hit[i] = ch_req[i] && c_valid[i] &&
                       (ch_addr[i*AW +: AW] == c_tag[i]);
    end

    jtframe_rr_arbiter #(.CH(CH)) u_hit (
        .req (c_hit),
        .ptr (ptr),
        .gnt (hit_gnt),
        .idx (hit_idx),
        .any (hit_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || blocked)
            c_valid <= '0;
        else if (st == WAIT && sdram_rdy)
            c_valid[win] <= 1'b1;
        if (st == WAIT && sdram_rdy) begin
            c_tag[win]  <= sdram_addr;
            c_data[win] <= data_read;
        end
    end
`else
    assign hit_any = 1'b0;
`endif

    always_comb begin
        st_nx = st;
        unique case (st)
            IDLE:  if (!blocked && gnt_any && !hit_any) st_nx = ISSUE;
            ISSUE: if (sdram_ack) st_nx = WAIT;
            WAIT:  if (sdram_rdy) st_nx = DONE;
            DONE:  st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st         <= IDLE;
            ptr        <= '0;
            win        <= '0;
            sdram_addr <= '0;
            ch_ok      <= '0;
            ch_dout    <= '0;
        end else begin
            st    <= st_nx;
            ch_ok <= '0;
            if (st == IDLE && !blocked) begin
`ifdef JTFRAME_ROMMUX_CACHE_EN
                if (hit_any) begin
                    ch_ok   <= hit_gnt;
                    ch_dout <= c_data[hit_idx];
                    ptr     <= CHW'(rr_next(int'(hit_idx), CH));
                end else
`endif
                if (gnt_any) begin
                    win        <= gnt_idx;
                    sdram_addr <= gnt_addr;
                    ptr        <= CHW'(rr_next(int'(gnt_idx), CH));
                end
            end
            if (st == WAIT && sdram_rdy && fetch_ok) begin
                ch_ok[win] <= 1'b1;
                ch_dout    <= data_read;
            end
        end
    end

endmodule
